data_mem_arbiter: RTL

Sequences every access to the single-ported 16-bit data memory and shares it between the Pipelined_Processor data port (MemRead/MemWrite/MemAddr/MemData/MemOutput) and a debug/loader port. It drives the memory's one-cycle command strobe and counts fixed read wait states. It stalls the processor with MemStall until its access completes, and hands the debug port a req/ack handshake. CPU has priority, and a starvation counter bounds debug latency.

---
 rtl/data_mem_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// Arbiter and sequencer for the single-ported data memory, shared between the CPU
// data port and a debug/loader port. CPU has priority; a starvation counter bounds debug latency.
module data_mem_arbiter #(
    parameter int DataWidth   = 16,
    parameter int AddrWidth   = 16,
    parameter int WaitStates  = 2,
    parameter int StarveLimit = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic [AddrWidth-1:0] MemAddr,
    input  logic [DataWidth-1:0] MemData,
    output logic [DataWidth-1:0] MemOutput,
    output logic                 MemStall,
    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic [AddrWidth-1:0] dbg_addr,
    input  logic [DataWidth-1:0] dbg_wdata,
    output logic [DataWidth-1:0] dbg_rdata,
    output logic                 dbg_ack,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    input  logic [DataWidth-1:0] mem_rdata
);

    localparam logic [3:0] WaitLoad   = 4'(WaitStates);
    localparam logic [3:0] StarveSat  = 4'(StarveLimit);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     state;
    logic       ownerDbg;
    logic       isWrite;
    logic [3:0] waitCnt;
    logic [3:0] starveCnt;
    logic       cpuReq;
    logic       dbgWins;

    assign cpuReq  = MemRead | MemWrite;
    // Debug only overrides a requesting CPU once it has lost StarveLimit times in a row.
    assign dbgWins = dbg_req & (~cpuReq | (starveCnt == StarveSat));

    assign MemStall = cpuReq & ~((state == DONE) & ~ownerDbg);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            ownerDbg  <= 1'b0;
            isWrite   <= 1'b0;
            waitCnt   <= 4'd0;
            starveCnt <= 4'd0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            MemOutput <= '0;
            dbg_rdata <= '0;
            dbg_ack   <= 1'b0;
        end else begin
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            dbg_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpuReq | dbg_req) begin
                        state    <= ISSUE;
                        ownerDbg <= dbgWins;
                        mem_en   <= 1'b1;
                        if (dbgWins) begin
                            isWrite   <= dbg_we;
                            mem_we    <= dbg_we;
                            mem_addr  <= dbg_addr;
                            mem_wdata <= dbg_wdata;
                            starveCnt <= 4'd0;
                        end else begin
                            // A simultaneous write+read from the CPU is a write.
                            isWrite   <= MemWrite;
                            mem_we    <= MemWrite;
                            mem_addr  <= MemAddr;
                            mem_wdata <= MemData;
                            if (dbg_req && (starveCnt != StarveSat)) begin
                                starveCnt <= starveCnt + 4'd1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (isWrite) begin
                        state   <= DONE;
                        dbg_ack <= ownerDbg;
                    end else begin
                        state   <= WAIT;
                        waitCnt <= WaitLoad;
                    end
                end
                WAIT: begin
                    if (waitCnt == 4'd1) begin
                        state   <= DONE;
                        dbg_ack <= ownerDbg;
                        if (ownerDbg) begin
                            dbg_rdata <= mem_rdata;
                        end else begin
                            MemOutput <= mem_rdata;
                        end
                    end else begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
